// File: rtl/grain_keystream_ctrl.sv
// Sequencer for a Grain-style LFSR+NFSR keystream datapath: seed load, warm-up, then valid/ready streaming.
// Optional macro GRAIN_INIT_FB_EN drives init_fb high during warm-up; without it init_fb is tied low.
module grain_keystream_ctrl #(
  parameter int WARMUP_CYCLES = 48,
  parameter int WCNT_W        = 8,
  parameter int LEN_W         = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] num_bits,
  input  logic             z_in,
  input  logic             ks_ready,
  output logic             par_load,
  output logic             shift_en,
  output logic             init_fb,
  output logic             ks_valid,
  output logic             ks_bit,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WARMUP = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Terminal warm-up count; unused when WARMUP_CYCLES is 0 because LOAD goes straight to RUN.
  localparam logic [WCNT_W-1:0] WARM_LAST =
    WCNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              handshake;

  assign handshake = (state_q == S_RUN) && ks_ready;

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start && (num_bits != '0)) begin
          rem_d   = num_bits;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wcnt_d  = '0;
        state_d = (WARMUP_CYCLES == 0) ? S_RUN : S_WARMUP;
      end
      S_WARMUP: begin
        if (wcnt_q == WARM_LAST) begin
          wcnt_d  = '0;
          state_d = S_RUN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (handshake) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs decode the registered state; only shift_en in RUN looks at ks_ready.
  assign par_load = (state_q == S_LOAD);
  assign shift_en = (state_q == S_WARMUP) || handshake;
  assign ks_valid = (state_q == S_RUN);
  assign ks_bit   = ks_valid & z_in;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

`ifdef GRAIN_INIT_FB_EN
  assign init_fb = (state_q == S_WARMUP);
`else
  assign init_fb = 1'b0;
`endif

endmodule

// File: tb/tb_grain_keystream_ctrl.sv
// Scoreboard bench for grain_keystream_ctrl with a toy LFSR+NFSR datapath attached to the controller.
module tb_grain_keystream_ctrl;

  localparam int W     = 48;
  localparam int LEN_W = 16;
  localparam logic [15:0] LSEED = 16'hACE1;
  localparam logic [15:0] NSEED = 16'h5A3C;
`ifdef GRAIN_INIT_FB_EN
  localparam logic INIT_FB = 1'b1;
`else
  localparam logic INIT_FB = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] num_bits = '0;
  logic             z_in;
  logic             ks_ready = 1'b0;
  logic             par_load, shift_en, init_fb, ks_valid, ks_bit, busy, done;

  int total = 0;
  int bad   = 0;
  int n_load, n_warm, n_fb, n_done, n_hs;
  logic exp_q[$];
  logic prev_stall = 1'b0;
  logic prev_bit   = 1'b0;

  grain_keystream_ctrl #(.WARMUP_CYCLES(W), .WCNT_W(8), .LEN_W(LEN_W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .num_bits(num_bits), .z_in(z_in),
    .ks_ready(ks_ready), .par_load(par_load), .shift_en(shift_en), .init_fb(init_fb),
    .ks_valid(ks_valid), .ks_bit(ks_bit), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Toy keystream datapath
  function automatic logic z_of(input logic [15:0] l, input logic [15:0] n);
    return n[0] ^ l[1] ^ n[6] ^ (l[3] & n[10]) ^ (l[8] & l[12]) ^ n[13];
  endfunction

  function automatic logic [31:0] step(input logic [15:0] l, input logic [15:0] n, input logic fb);
    logic z, lf, nf;
    z  = z_of(l, n);
    lf = l[0] ^ l[2] ^ l[7] ^ l[11] ^ (fb & z);
    nf = l[0] ^ n[0] ^ n[5] ^ (n[3] & n[9]) ^ n[12] ^ (fb & z);
    return {lf, l[15:1], nf, n[15:1]};
  endfunction

  logic [15:0] dp_l, dp_n;
  always @(posedge Clk) begin
    if (reset) begin
      dp_l <= '0;
      dp_n <= '0;
    end else if (par_load) begin
      dp_l <= LSEED;
      dp_n <= NSEED;
    end else if (shift_en) begin
      {dp_l, dp_n} <= step(dp_l, dp_n, init_fb);
    end
  end
  assign z_in = z_of(dp_l, dp_n);

  // Golden stream: seed, W warm-up shifts, then one bit per shift
  task automatic push_expected(input int n);
    logic [15:0] l, nn;
    l  = LSEED;
    nn = NSEED;
    for (int i = 0; i < W; i++) {l, nn} = step(l, nn, INIT_FB);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(z_of(l, nn));
      {l, nn} = step(l, nn, 1'b0);
    end
  endtask

  // Per-cycle monitor: event counters plus scoreboard pops on each handshake
  always @(negedge Clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (par_load) n_load++;
      if (shift_en && !ks_valid) n_warm++;
      if (init_fb) n_fb++;
      if (done) n_done++;
      if (ks_valid) begin
        total++;
        if (shift_en !== ks_ready) begin
          bad++;
          $display("FAIL run_shift_en: got %0b expected %0b", shift_en, ks_ready);
        end
        if (prev_stall) begin
          total++;
          if (ks_bit !== prev_bit) begin
            bad++;
            $display("FAIL stall_stable: got %0b expected %0b", ks_bit, prev_bit);
          end
        end
        if (ks_ready) begin
          n_hs++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_bit: got bit %0b expected no handshake", ks_bit);
          end else begin
            logic e;
            e = exp_q.pop_front();
            if (ks_bit !== e) begin
              bad++;
              $display("FAIL ks_bit: got %0b expected %0b", ks_bit, e);
            end
          end
        end
        prev_stall = !ks_ready;
        prev_bit   = ks_bit;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_counts();
    n_load = 0; n_warm = 0; n_fb = 0; n_done = 0; n_hs = 0;
  endtask

  task automatic start_req(input int n);
    cycle();
    start    = 1'b1;
    num_bits = LEN_W'(n);
    push_expected(n);
    sample();
    cycle();
    start    = 1'b0;
    num_bits = LEN_W'($urandom_range(1, 200));
    sample();
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!ks_valid && k < 200) begin
      cycle();
      sample();
      k++;
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin
      cycle();
      sample();
      k++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: got done=%0b expected 1 within 300 cycles", tag, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    sample();
    total++;
    if ({par_load, shift_en, init_fb, ks_valid, ks_bit, done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {par_load, shift_en, init_fb, ks_valid, ks_bit, done});
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int k;
    clear_counts();
    ks_ready = 1'b1;
    start_req(8);
    wait_valid(k);
    total++;
    if (k != 2 + W) begin
      bad++;
      $display("FAIL latency: got %0d expected %0d", k, 2 + W);
    end
    wait_done("basic");
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL done_busy: got %0b expected 1", busy);
    end
    cycle();
    sample();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL after_done: got busy=%0b done=%0b expected 0 0", busy, done);
    end
    total++;
    if (n_load != 1 || n_warm != W || n_done != 1 || n_hs != 8) begin
      bad++;
      $display("FAIL basic_counts: got load=%0d warm=%0d done=%0d hs=%0d expected 1 %0d 1 8",
               n_load, n_warm, n_done, n_hs, W);
    end
    total++;
    if (n_fb != (INIT_FB ? W : 0)) begin
      bad++;
      $display("FAIL init_fb_cycles: got %0d expected %0d", n_fb, INIT_FB ? W : 0);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_leftover: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int k;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    clear_counts();
    ks_ready = 1'b0;
    start_req(4);
    wait_valid(k);
    for (int i = 0; i < 7; i++) begin
      cycle();
      ks_ready = pat[i][0];
      sample();
    end
    ks_ready = 1'b1;
    wait_done("stall");
    total++;
    if (n_hs != 4 || n_done != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_counts: got hs=%0d done=%0d left=%0d expected 4 1 0",
               n_hs, n_done, exp_q.size());
    end
    cycle();
    sample();
  endtask

  task automatic test_ignored();
    int k;
    clear_counts();
    cycle();
    start    = 1'b1;
    num_bits = '0;
    sample();
    cycle();
    start = 1'b0;
    sample();
    repeat (3) begin
      cycle();
      sample();
    end
    total++;
    if (busy !== 1'b0 || n_load != 0 || n_done != 0) begin
      bad++;
      $display("FAIL zero_len: got busy=%0b load=%0d done=%0d expected 0 0 0", busy, n_load, n_done);
    end
    ks_ready = 1'b1;
    start_req(5);
    repeat (10) begin
      cycle();
      sample();
    end
    cycle();
    start    = 1'b1;
    num_bits = LEN_W'(9);
    sample();
    cycle();
    start = 1'b0;
    sample();
    wait_valid(k);
    cycle();
    start    = 1'b1;
    num_bits = LEN_W'(12);
    sample();
    cycle();
    start = 1'b0;
    sample();
    wait_done("ignored");
    repeat (4) begin
      cycle();
      sample();
    end
    total++;
    if (n_hs != 5 || n_load != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ignored_start: got hs=%0d load=%0d busy=%0b left=%0d expected 5 1 0 0",
               n_hs, n_load, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_counts();
    ks_ready = 1'b1;
    start_req(10);
    wait_valid(k);
    k = 0;
    while (n_hs < 3 && k < 50) begin
      cycle();
      sample();
      k++;
    end
    cycle();
    reset = 1'b1;
    sample();
    cycle();
    sample();
    total++;
    if ({par_load, shift_en, init_fb, ks_valid, ks_bit, busy, done} !== 7'b0) begin
      bad++;
      $display("FAIL mid_reset: got %b expected 0000000",
               {par_load, shift_en, init_fb, ks_valid, ks_bit, busy, done});
    end
    total++;
    if (n_hs != 3 || n_done != 0) begin
      bad++;
      $display("FAIL mid_reset_counts: got hs=%0d done=%0d expected 3 0", n_hs, n_done);
    end
    exp_q.delete();
    cycle();
    reset = 1'b0;
    sample();
    clear_counts();
    start_req(10);
    wait_done("restart");
    total++;
    if (n_hs != 10 || n_done != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL restart_counts: got hs=%0d done=%0d left=%0d expected 10 1 0",
               n_hs, n_done, exp_q.size());
    end
    cycle();
    sample();
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_basic();
    test_stall();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
